// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter_if
//  Description : Write-back request, decode scoreboard and register-file
//                write-port bundle for regfile_wb_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 6,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               issue_valid;
  logic [AW-1:0]      issue_addr;
  logic [AW-1:0]      rd_addr1;
  logic [AW-1:0]      rd_addr2;
  logic               rd_busy1;
  logic               rd_busy2;
  logic               we3;
  logic [AW-1:0]      addr3;
  logic [DW-1:0]      writeData3;
  logic [31:0]        busy_mask;
  logic               err_addr;

  modport master (
    output req_valid, req_addr, req_data, issue_valid, issue_addr, rd_addr1, rd_addr2,
    input  req_ready, rd_busy1, rd_busy2, we3, addr3, writeData3, busy_mask, err_addr
  );

  modport slave (
    input  req_valid, req_addr, req_data, issue_valid, issue_addr, rd_addr1, rd_addr2,
    output req_ready, rd_busy1, rd_busy2, we3, addr3, writeData3, busy_mask, err_addr
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Shares the register file write port between write-back
//                sources and tracks per-register pending writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NREQ     = 3,
  parameter int AW       = 6,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  wire                  clk,
  input  wire                  reset_n,
  regfile_wb_arbiter_if.slave  bus
);

  localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);
  localparam logic [3:0] c_wait_sat = 4'hF;

  logic [3:0]      r_wait_cnt [NREQ];
  logic [NREQ-1:0] w_promo;
  logic [NREQ-1:0] w_cand;
  logic [NREQ-1:0] w_grant;
  logic            w_xfer;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;
  logic            w_issue_ok;
  logic [31:0]     w_set;
  logic [31:0]     w_clr;

  logic            r_we3;
  logic [AW-1:0]   r_addr3;
  logic [DW-1:0]   r_wdata3;
  logic [31:0]     r_busy;
  logic            r_err;

  for (genvar i = 0; i < NREQ; i++) begin : g_wait
    assign w_promo[i] = bus.req_valid[i] && (r_wait_cnt[i] >= c_max_wait);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_wait_cnt[i] <= 4'd0;
      end else if (bus.req_valid[i] && !w_grant[i]) begin
        if (r_wait_cnt[i] != c_wait_sat) begin
          r_wait_cnt[i] <= r_wait_cnt[i] + 4'd1;
        end
      end else begin
        r_wait_cnt[i] <= 4'd0;
      end
    end
  end

  // Starved sources form the candidate set when present; lowest set bit wins.
  assign w_cand  = (|w_promo) ? w_promo : bus.req_valid;
  assign w_grant = reset_n ? (w_cand & (~w_cand + NREQ'(1))) : '0;
  assign w_xfer  = |w_grant;

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = bus.req_addr[i*AW +: AW];
        w_sel_data = bus.req_data[i*DW +: DW];
      end
    end
  end

  // Register 0 is never reserved, and illegal addresses never reach the file.
  assign w_issue_ok = bus.issue_valid && !bus.issue_addr[5] && (bus.issue_addr[4:0] != 5'd0);
  assign w_set      = w_issue_ok ? (32'd1 << bus.issue_addr[4:0]) : 32'd0;
  assign w_clr      = r_we3 ? (32'd1 << r_addr3[4:0]) : 32'd0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we3    <= 1'b0;
      r_addr3  <= '0;
      r_wdata3 <= '0;
      r_busy   <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_we3 <= w_xfer && !w_sel_addr[5];
      if (w_xfer && !w_sel_addr[5]) begin
        r_addr3  <= w_sel_addr;
        r_wdata3 <= w_sel_data;
      end
      if (w_xfer && w_sel_addr[5]) begin
        r_err <= 1'b1;
      end
      // A same-edge issue re-reserves the register after its write retires.
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end

  assign bus.req_ready  = w_grant;
  assign bus.we3        = r_we3;
  assign bus.addr3      = r_addr3;
  assign bus.writeData3 = r_wdata3;
  assign bus.busy_mask  = r_busy;
  assign bus.err_addr   = r_err;
  assign bus.rd_busy1   = r_busy[bus.rd_addr1[4:0]] && (bus.rd_addr1 != '0) && !bus.rd_addr1[5];
  assign bus.rd_busy2   = r_busy[bus.rd_addr2[4:0]] && (bus.rd_addr2 != '0) && !bus.rd_addr2[5];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Directed-vector bench for regfile_wb_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  regfile_wb_arbiter_if #(.NREQ(3), .AW(6), .DW(32)) bus ();

  regfile_wb_arbiter #(.NREQ(3), .AW(6), .DW(32), .MAX_WAIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [5:0] a, input logic [31:0] d);
    bus.req_addr[i*6 +: 6]  = a;
    bus.req_data[i*32 +: 32] = d;
  endtask

  logic [2:0] exp_rdy [6];
  logic [5:0] exp_a3  [6];

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n         = 1'b1;
    bus.req_valid   = 3'b000;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
    bus.rd_addr1    = '0;
    bus.rd_addr2    = '0;
    #1 reset_n = 1'b0;

    // Reset with all sources requesting
    bus.req_valid = 3'b111;
    set_req(1, 6'd5, 32'hDEADBEEF);
    tick();
    tick();
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_we3", 64'(bus.we3), 64'h0);
    chk("rst_addr3", 64'(bus.addr3), 64'h0);
    chk("rst_wd3", 64'(bus.writeData3), 64'h0);
    chk("rst_busy", 64'(bus.busy_mask), 64'h0);
    chk("rst_err", 64'(bus.err_addr), 64'h0);

    reset_n = 1'b1;
    bus.req_valid = 3'b010;
    #1;
    chk("first_ready", 64'(bus.req_ready), 64'b010);
    tick();
    bus.req_valid = 3'b000;
    chk("first_we3", 64'(bus.we3), 64'h1);
    chk("first_addr3", 64'(bus.addr3), 64'd5);
    chk("first_wd3", 64'(bus.writeData3), 64'hDEADBEEF);
    tick();
    chk("idle_we3", 64'(bus.we3), 64'h0);
    chk("idle_addr3_hold", 64'(bus.addr3), 64'd5);

    // Sources 0 and 2 contend: 4 wins for 0, then promoted 2, then 0
    exp_rdy = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b100, 3'b001};
    exp_a3  = '{6'd1, 6'd1, 6'd1, 6'd1, 6'd2, 6'd1};
    set_req(0, 6'd1, 32'h0000_0011);
    set_req(2, 6'd2, 32'h0000_0022);
    bus.req_valid = 3'b101;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("prio_ready_c%0d", c + 1), 64'(bus.req_ready), 64'(exp_rdy[c]));
      tick();
      chk($sformatf("prio_addr3_c%0d", c + 1), 64'(bus.addr3), 64'(exp_a3[c]));
    end
    bus.req_valid = 3'b000;
    tick();

    // Scoreboard: reserve r7, write it back, busy drops with the file write
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 6'd7;
    tick();
    bus.issue_valid = 1'b0;
    bus.rd_addr1    = 6'd7;
    #1;
    chk("sb_busy_c2", 64'(bus.rd_busy1), 64'h1);
    chk("sb_mask_c2", 64'(bus.busy_mask), 64'h80);
    tick();
    set_req(0, 6'd7, 32'h0000_0077);
    bus.req_valid = 3'b001;
    #1;
    chk("sb_ready_c3", 64'(bus.req_ready), 64'b001);
    tick();
    bus.req_valid = 3'b000;
    chk("sb_we3_c4", 64'(bus.we3), 64'h1);
    chk("sb_busy_c4", 64'(bus.rd_busy1), 64'h1);
    tick();
    chk("sb_busy_c5", 64'(bus.rd_busy1), 64'h0);

    // Set/clear collision on r9
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 6'd9;
    tick();
    bus.issue_valid = 1'b0;
    set_req(0, 6'd9, 32'h0000_0099);
    bus.req_valid = 3'b001;
    tick();
    bus.req_valid   = 3'b000;
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 6'd9;
    chk("coll_we3", 64'(bus.we3), 64'h1);
    tick();
    bus.issue_valid = 1'b0;
    bus.rd_addr2    = 6'd9;
    #1;
    chk("coll_busy9", 64'(bus.busy_mask[9]), 64'h1);
    chk("coll_rdbusy2", 64'(bus.rd_busy2), 64'h1);

    // Address 0: written, never reserved
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 6'd0;
    set_req(2, 6'd0, 32'h0000_1234);
    bus.req_valid = 3'b100;
    tick();
    bus.issue_valid = 1'b0;
    bus.req_valid   = 3'b000;
    bus.rd_addr1    = 6'd0;
    #1;
    chk("r0_we3", 64'(bus.we3), 64'h1);
    chk("r0_addr3", 64'(bus.addr3), 64'd0);
    chk("r0_wd3", 64'(bus.writeData3), 64'h1234);
    chk("r0_busy0", 64'(bus.busy_mask[0]), 64'h0);
    chk("r0_rdbusy", 64'(bus.rd_busy1), 64'h0);

    // Illegal address: handshake completes, no write, sticky error
    tick();
    set_req(1, 6'h21, 32'h0000_5555);
    bus.req_valid   = 3'b010;
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 6'h21;
    bus.rd_addr2    = 6'h29;
    #1;
    chk("ill_ready", 64'(bus.req_ready), 64'b010);
    chk("ill_rdbusy_b5", 64'(bus.rd_busy2), 64'h0);
    tick();
    bus.req_valid   = 3'b000;
    bus.issue_valid = 1'b0;
    chk("ill_we3", 64'(bus.we3), 64'h0);
    chk("ill_err", 64'(bus.err_addr), 64'h1);
    chk("ill_busy1", 64'(bus.busy_mask[1]), 64'h0);
    tick();
    tick();
    chk("ill_err_sticky", 64'(bus.err_addr), 64'h1);

    // Reset in the cycle after a grant
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 6'd3;
    tick();
    bus.issue_valid = 1'b0;
    set_req(0, 6'd4, 32'h0000_0044);
    bus.req_valid = 3'b001;
    tick();
    chk("mid_we3_pre", 64'(bus.we3), 64'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_we3", 64'(bus.we3), 64'h0);
    chk("mid_busy", 64'(bus.busy_mask), 64'h0);
    chk("mid_err", 64'(bus.err_addr), 64'h0);
    chk("mid_ready", 64'(bus.req_ready), 64'h0);
    tick();
    bus.req_valid = 3'b000;
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the CPU's 32-entry register file. It shares the file's single write port (`we3`/`addr3`/`writeData3`) between several write-back sources: ALU, load unit and multi-cycle mul/div. It also keeps a per-register busy bit so the decode stage can stall on read-after-write hazards. It sits between the execute/memory stages and the register file, and it is the only driver of the file's write port.

## Interface
- `NREQ`, 3: number of write-back requesters; index 0 has the highest base priority.
- `AW`, 6: register address width, matching the register file's address ports.
- `DW`, 32: data width.
- `MAX_WAIT`, 4: consecutive lost cycles after which a requester is promoted (range 1..15).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  write-back request per source.
- `req_ready`  out  NREQ  grant per source; combinational, one-hot or zero.
- `req_addr`  in  NREQ*AW  destination register per source; source i is at bits [i*AW +: AW].
- `req_data`  in  NREQ*DW  write data per source; source i is at bits [i*DW +: DW].
- `issue_valid`  in  1  decode reserves a destination register this cycle.
- `issue_addr`  in  AW  register being reserved.
- `rd_addr1`, `rd_addr2`  in  AW  decode source operands.
- `rd_busy1`, `rd_busy2`  out  1  operand has a pending write; combinational.
- `we3`  out  1  register-file write enable; registered.
- `addr3`  out  AW  register-file write address; registered.
- `writeData3`  out  DW  register-file write data; registered.
- `busy_mask`  out  32  current scoreboard, for debug.
- `err_addr`  out  1  sticky flag: an illegal address (bit 5 set) was seen.

## Operation
- A transfer from source i happens in cycle N when `req_valid[i] && req_ready[i]` is high at the rising edge ending cycle N.
- At most one grant per cycle. `req_ready` depends only on `req_valid` and internal state, never on `req_data`.
- A source must hold its valid, address and data stable until it is granted.
- Grant selection:
  - If any valid source has `wait_cnt[i] >= MAX_WAIT`, the lowest such index wins.
  - Otherwise the lowest valid index wins.
- Wait counters:
  - `wait_cnt[i]` increments, saturating at 15, on each cycle where source i is valid but not granted.
  - It clears when source i is granted or when `req_valid[i]` is low.
- Write port: on a transfer from source i, the next cycle drives `we3=1`, `addr3=req_addr[i]`, `writeData3=req_data[i]`. With no transfer, `we3=0` and `addr3`/`writeData3` hold their previous values.
- Illegal address (bit 5 of the address set):
  - The handshake still completes.
  - `we3` stays 0 for that write.
  - `err_addr` sets and stays set until reset.
- Address 0: the write goes to the file as normal. Busy bit 0 is never set.
- Scoreboard:
  - `busy[a]` sets at the edge where `issue_valid` is high with `issue_addr=a` (a≠0, legal address).
  - `busy[a]` clears at the edge ending a cycle where `we3=1` and `addr3=a`.
  - If a set and a clear hit the same register at the same edge, the set wins.
  - Issuing to a register that is already busy leaves it set.
- `rd_busyK = busy[rd_addrK[4:0]] && rd_addrK != 0 && !rd_addrK[5]`.

## Timing
- Reset (asynchronous assert, synchronous release): `we3=0`, `addr3=0`, `writeData3=0`, `busy_mask=0`, `err_addr=0`, all wait counters 0, `req_ready=0` while `reset_n` is low.
- A reset in the middle of a write discards any registered write that has not yet been presented.
- Latency: handshake at edge E → `we3` high in the cycle after E → data readable from the file one cycle later. The busy bit drops at the same edge the file captures the data, so `rd_busy` and the file contents stay consistent.
- Throughput: one write per cycle, with back-to-back grants allowed.
- Under continuous contention, no requester waits more than MAX_WAIT + NREQ − 1 cycles.

## Test plan
- Reset: hold `reset_n=0` while sources drive valid → `req_ready=000`, `we3=0`, `busy_mask=0`. Release, then source 1 drives valid with addr 5 and data 0xDEADBEEF → `req_ready=010` that cycle; next cycle `we3=1`, `addr3=5`, `writeData3=0xDEADBEEF`.
- Priority and promotion: sources 0 and 2 valid continuously, MAX_WAIT=4 → source 0 granted for 4 cycles, source 2 granted in the 5th cycle, then source 0 again.
- Scoreboard: issue addr 7 at edge 1 → `rd_busy1` high for `rd_addr1=7` from cycle 2. Source 0 writes r7 (handshake at edge 3, `we3` in cycle 4) → `rd_busy1` low from cycle 5.
- Set and clear collide: `we3` cycle for r9 coincides with `issue_valid` for r9 → `busy[9]` remains 1.
- Address edge cases: write to r0 → `we3=1`, `addr3=0`, `busy[0]` stays 0, `rd_busy` is 0 for r0. Write to address 6'h21 → handshake completes, `we3=0`, `err_addr=1` and sticky.
- Reset mid-operation: assert `reset_n` low in the cycle after a grant → `we3` drops to 0 immediately and `busy_mask` clears.
